prio_scan_encoder: RTL
======================

// Module: prio_scan_encoder
// PURPOSE
//  Parametrised, sequential successor of the combinational 8-to-3 priority encoder.
//  - Captures an N-bit request vector through a valid/ready handshake.
//  - Emits the index of every set bit, one per output handshake, in priority order.
//  - Flags the final index of each vector.
//  - Sits between interrupt/request aggregation and a serial consumer (arbiter, IRQ dispatcher).
// PARAMETERS
//  N          8    request vector width; legal range 2..256
//  MSB_FIRST  1    1: highest set bit is emitted first; 0: lowest set bit first
//  W          $clog2(N)  localparam: index width, not overridable
// PORTS
//  clk            in   1    single clock, rising edge
//  rst_n          in   1    asynchronous, active-low reset
//  req_valid      in   1    request vector valid
//  req_ready      out  1    block can accept a vector (high only in IDLE)
//  req_data       in   N    request vector
//  out_valid      out  1    out_index is valid
//  out_ready      in   1    consumer accepts out_index
//  out_index      out  W    encoded index of the current highest-priority pending bit
//  out_last       out  1    current index is the last pending bit of this vector
//  zero_req       out  1    one-cycle pulse: an all-zero vector was accepted and dropped
//  out_remaining  out  W+1  pending-bit count incl. current (only with PRIO_SCAN_COUNT_EN)
// BEHAVIOUR
//  - Reset (rst_n low, async):
//    - FSM=IDLE; pending=0.
//    - out_valid=0, out_index=0, out_last=0, zero_req=0, out_remaining=0.
//    - req_ready=1 once in IDLE.
//    - A reset mid-scan discards all pending bits.
//  - FSM states: IDLE, SCAN.
//  - IDLE:
//    - req_ready=1, out_valid=0.
//    - Accept on req_valid&&req_ready.
//    - req_data!=0: pending<=req_data; out_index<=enc(req_data); out_last<=(popcount==1); go SCAN.
//    - req_data==0: zero_req=1 for the next cycle only; stay IDLE.
//  - SCAN:
//    - req_ready=0, out_valid=1.
//    - On out_valid&&out_ready, clear the emitted bit: pending'=pending&~(1<<out_index).
//    - If out_last: go IDLE, out_valid=0 next cycle.
//    - Otherwise: out_index<=enc(pending'), out_last<=(popcount(pending')==1).
//  - enc(): MSB_FIRST=1 -> highest set bit index; MSB_FIRST=0 -> lowest set bit index.
//  - Latency:
//    - Vector accepted in cycle t -> first out_valid in t+1.
//    - One index per cycle with out_ready held high.
//    - req_ready reasserts the cycle after the last handshake; no overlap between vectors.
//  - Backpressure: while out_valid&&!out_ready, out_index, out_last and out_remaining are held stable.
//  - All outputs are registered except req_ready, which decodes the FSM state.
//  - Index width: out_index is zero-extended for non-power-of-2 N.
//    Emitted values never exceed N-1.
// CONFIGURATION
//  Macro: PRIO_SCAN_COUNT_EN.
//  - Defined:
//    - out_remaining port exists.
//    - Loaded with popcount(req_data) on accept.
//    - Decrements by 1 per output handshake; 0 in IDLE.
//  - Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  prio_scan_pkg:
//  - typedef enum logic {IDLE, SCAN} prio_scan_state_t
//  - function popcount.
//  Sub-module prio_enc_comb #(N, MSB_FIRST):
//  - combinational N -> W priority encoder plus any-bit flag.
//  - Instantiated once on the next-pending vector.
// TESTING (N=8 unless stated; out_ready=1 unless stated)
//  1 MSB_FIRST=1, req 8'b1010_0100 -> out_index 7,5,2 on consecutive cycles; out_last on 2; req_ready=1 next cycle
//  2 req 8'h00 -> zero_req high exactly 1 cycle; out_valid stays 0; req_ready stays 1
//  3 req 8'h81, out_ready=0 for 3 cycles -> out_index 7 held stable; then 7, then 0 with out_last
//  4 MSB_FIRST=0, req 8'b1010_0100 -> out_index 2,5,7; out_last on 7
//  5 rst_n low after first beat of 8'hF0 -> out_valid=0 immediately; after release, req 8'h01 -> index 0, out_last=1
//  6 PRIO_SCAN_COUNT_EN, req 8'hFF -> out_remaining 8,7,...,1 with out_index 7..0; 0 in IDLE

Source files
------------

// File: rtl/prio_scan_encoder_pkg.sv
// Shared types and helpers for the sequential priority scan encoder.
// Latency: n/a (types and a combinational helper function only).
// Backpressure: n/a.
// Contents: prio_scan_state_t (IDLE/SCAN) and popcount() over a vector of up to 256 bits.
package prio_scan_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } prio_scan_state_t;

    // Widest request vector the block supports; popcount() zero-extends to this width.
    localparam int PRIO_SCAN_MAX_N = 256;

    function automatic int unsigned popcount(input logic [PRIO_SCAN_MAX_N-1:0] v);
        int unsigned cnt = 0;
        for (int i = 0; i < PRIO_SCAN_MAX_N; i++) begin
            cnt += {31'b0, v[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/prio_scan_encoder_if.sv
// Request/index handshake bundle between a request source/consumer and prio_scan_encoder.
// Latency: n/a (wires only).
// Backpressure: req_valid/req_ready on the request side, out_valid/out_ready on the index side.
// Ports: req_valid, req_ready, req_data[N], out_valid, out_ready, out_index[W], out_last, zero_req,
//        and out_remaining[W+1] only when PRIO_SCAN_COUNT_EN is defined.
// Modports: master = environment side, slave = encoder side.
interface prio_scan_encoder_if #(
    parameter int N = 8
);
    localparam int W = $clog2(N);

    logic         req_valid;
    logic         req_ready;
    logic [N-1:0] req_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_index;
    logic         out_last;
    logic         zero_req;
`ifdef PRIO_SCAN_COUNT_EN
    logic [W:0]   out_remaining;
`endif

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_index, out_last, zero_req
`ifdef PRIO_SCAN_COUNT_EN
        , input out_remaining
`endif
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_index, out_last, zero_req
`ifdef PRIO_SCAN_COUNT_EN
        , output out_remaining
`endif
    );

endinterface

// File: rtl/prio_scan_encoder_prio_enc_comb.sv
// Combinational N -> W priority encoder with an any-bit-set flag.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
// Ports: i_vec (N) in; o_idx (W) highest (MSB_FIRST=1) or lowest (MSB_FIRST=0) set bit; o_any.
module prio_enc_comb
    import prio_scan_pkg::*;
#(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1,
    localparam int W        = $clog2(N)
) (
    input  logic [N-1:0] i_vec,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    // The loop direction picks the winner: the last set bit visited overrides earlier ones.
    always_comb begin
        o_idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < N; i++) begin
                if (i_vec[i]) o_idx = W'(i);
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                if (i_vec[i]) o_idx = W'(i);
            end
        end
    end

    assign o_any = |i_vec;

endmodule

// File: rtl/prio_scan_encoder.sv
// Captures an N-bit request vector and emits the index of each set bit, one per handshake, in priority order.
// Latency: vector accepted in cycle t -> first index valid in t+1; one index per cycle while out_ready is high.
// Backpressure: out_index/out_last/out_remaining hold while out_valid && !out_ready; req_ready is high only in IDLE.
// Ports: clk, rst_n (async, active-low), bus (prio_scan_encoder_if.slave).
// Optional: define PRIO_SCAN_COUNT_EN to add the out_remaining pending-bit counter.
module prio_scan_encoder
    import prio_scan_pkg::*;
#(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    prio_scan_encoder_if.slave bus
);

    localparam int W  = $clog2(N);
    localparam int WR = W + 1;

    prio_scan_state_t r_state;
    logic [N-1:0]     r_pending;
    logic [W-1:0]     r_index;
    logic             r_last;
    logic             r_vld;
    logic             r_zero;
`ifdef PRIO_SCAN_COUNT_EN
    logic [W:0]       r_rem;
`endif

    logic [N-1:0]     w_onehot;
    logic [N-1:0]     w_pend_clr;
    logic [N-1:0]     w_next_vec;
    logic [W-1:0]     w_enc_idx;
    logic             w_enc_any;
    int unsigned      w_next_cnt;
    logic             w_next_last;
    logic             w_req_fire;
    logic             w_out_fire;

    // One encoder serves both states: in IDLE it looks at the incoming vector,
    // in SCAN at the pending set with the currently presented bit already removed.
    assign w_onehot    = N'(1) << r_index;
    assign w_pend_clr  = r_pending & ~w_onehot;
    assign w_next_vec  = (r_state == IDLE) ? bus.req_data : w_pend_clr;
    assign w_next_cnt  = popcount(PRIO_SCAN_MAX_N'(w_next_vec));
    assign w_next_last = (w_next_cnt == 32'd1);

    assign w_req_fire  = bus.req_valid && (r_state == IDLE);
    assign w_out_fire  = r_vld && bus.out_ready;

    prio_enc_comb #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_enc (
        .i_vec (w_next_vec),
        .o_idx (w_enc_idx),
        .o_any (w_enc_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_index   <= '0;
            r_last    <= 1'b0;
            r_vld     <= 1'b0;
            r_zero    <= 1'b0;
`ifdef PRIO_SCAN_COUNT_EN
            r_rem     <= '0;
`endif
        end else begin
            r_zero <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req_fire) begin
                        if (w_enc_any) begin
                            r_pending <= bus.req_data;
                            r_index   <= w_enc_idx;
                            r_last    <= w_next_last;
                            r_vld     <= 1'b1;
                            r_state   <= SCAN;
`ifdef PRIO_SCAN_COUNT_EN
                            r_rem     <= WR'(w_next_cnt);
`endif
                        end else begin
                            // Empty vector: nothing to emit, just flag that it was swallowed.
                            r_zero <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (w_out_fire) begin
                        r_pending <= w_pend_clr;
                        if (r_last) begin
                            r_state <= IDLE;
                            r_vld   <= 1'b0;
                            r_last  <= 1'b0;
`ifdef PRIO_SCAN_COUNT_EN
                            r_rem   <= '0;
`endif
                        end else begin
                            r_index <= w_enc_idx;
                            r_last  <= w_next_last;
`ifdef PRIO_SCAN_COUNT_EN
                            r_rem   <= r_rem - 1'b1;
`endif
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (r_state == IDLE);
    assign bus.out_valid = r_vld;
    assign bus.out_index = r_index;
    assign bus.out_last  = r_last;
    assign bus.zero_req  = r_zero;
`ifdef PRIO_SCAN_COUNT_EN
    assign bus.out_remaining = r_rem;
`endif

endmodule
